// File: rtl/bp_btb.sv
// bp_btb: direct-mapped, tagged branch target buffer.
//
// Fetch side does a zero-latency combinational lookup of raddr0 and gets a
// hit flag, a taken prediction (counter MSB) and the next-fetch address.
// Execute/writeback trains one entry per cycle. After reset, and again after
// every flush, a hardware sweep invalidates every entry one per cycle. While
// the sweep runs, busy is high, lookups miss and training is dropped.
//
// Ports:
//   clk      in   clock; all state changes on posedge
//   rst_n    in   asynchronous active-low reset
//   flush    in   synchronous; restarts the clear sweep from entry 0
//   busy     out  high while the clear sweep is running
//   raddr0   in   [ADDR_W:1] lookup PC (word address)
//   rhit0    out  lookup hit
//   rtaken0  out  predicted taken
//   rdata0   out  [ADDR_W:1] predicted next-fetch address
//   wen      in   training update valid
//   waddr    in   [ADDR_W:1] branch PC being trained
//   wtaken   in   resolved direction
//   wdata    in   [ADDR_W:1] resolved taken target
//
// Handshake: there is no backpressure. A training beat is accepted on any
// posedge where wen & ~busy & ~flush; otherwise it is silently dropped.
// Lookups are always answered in the same cycle; busy is the only indication
// that the table is not yet usable (it mirrors the CLEAR state).

module bp_btb #(
  parameter int ADDR_W = 15,
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              busy,
  input  logic [ADDR_W:1]   raddr0,
  output logic              rhit0,
  output logic              rtaken0,
  output logic [ADDR_W:1]   rdata0,
  input  logic              wen,
  input  logic [ADDR_W:1]   waddr,
  input  logic              wtaken,
  input  logic [ADDR_W:1]   wdata
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  // Only the MSB set: weakly taken. Works for CTR_W == 1 as well.
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_MAX ^ (CTR_MAX >> 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   sweep_idx, sweep_idx_n;

  // Entry storage: deliberately without reset, the sweep initialises it.
  logic               vld_mem [DEPTH];
  logic [TAG_W-1:0]   tag_mem [DEPTH];
  logic [ADDR_W-1:0]  tgt_mem [DEPTH];
  logic [CTR_W-1:0]   ctr_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      sweep_idx <= '0;
    end else begin
      state     <= state_n;
      sweep_idx <= sweep_idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    sweep_idx_n = sweep_idx;
    if (flush) begin
      state_n     = CLEAR;
      sweep_idx_n = '0;
    end else if (state == CLEAR) begin
      sweep_idx_n = sweep_idx + 1'b1;
      if (&sweep_idx) begin
        state_n = READY;
      end
    end
  end

  assign busy = (state == CLEAR);

  // ---------------------------------------------------------------------------
  // Lookup (combinational, sees pre-update contents)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] ridx;
  logic [TAG_W-1:0] rtag;

  assign ridx    = raddr0[IDX_W:1];
  assign rtag    = raddr0[ADDR_W:IDX_W+1];
  assign rhit0   = ~busy & vld_mem[ridx] & (tag_mem[ridx] == rtag);
  assign rtaken0 = rhit0 & ctr_mem[ridx][CTR_W-1];
  assign rdata0  = rtaken0 ? tgt_mem[ridx] : (raddr0 + ADDR_W'(1));

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] widx;
  logic [TAG_W-1:0] wtag;
  logic             train;
  logic             whit;
  logic [CTR_W-1:0] wctr;
  logic [CTR_W-1:0] wctr_n;

  assign widx  = waddr[IDX_W:1];
  assign wtag  = waddr[ADDR_W:IDX_W+1];
  // busy is forced high asynchronously by rst_n, so a beat in flight while
  // reset is asserted is dropped here too.
  assign train = wen & ~busy & ~flush;
  assign whit  = vld_mem[widx] & (tag_mem[widx] == wtag);
  assign wctr  = ctr_mem[widx];

  always_comb begin
    wctr_n = wctr;
    if (wtaken) begin
      if (wctr != CTR_MAX) wctr_n = wctr + 1'b1;
    end else begin
      if (wctr != '0) wctr_n = wctr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      vld_mem[sweep_idx] <= 1'b0;
      ctr_mem[sweep_idx] <= '0;
    end else if (train) begin
      if (whit) begin
        ctr_mem[widx] <= wctr_n;
        if (wtaken) tgt_mem[widx] <= wdata;
      end else if (wtaken) begin
        // Allocate, replacing whatever lived at this index.
        vld_mem[widx] <= 1'b1;
        tag_mem[widx] <= wtag;
        tgt_mem[widx] <= wdata;
        ctr_mem[widx] <= CTR_WEAK;
      end
    end
  end

endmodule
